// File: rtl/psum_ofifo.sv
// Per-column psum output FIFOs that re-align skewed mac_array columns into full rows.
// Optional sticky overflow flag o_ovf is enabled by defining PSUM_OFIFO_OVF_FLAG_EN.
module psum_ofifo #(
  parameter int psum_bw = 16,
  parameter int col     = 8,
  parameter int depth   = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [psum_bw*col-1:0] in,
  input  logic [col-1:0]         wr,
  input  logic                   rd,
  output logic [psum_bw*col-1:0] out,
  output logic                   o_valid,
  output logic                   o_full,
  output logic                   o_empty
`ifdef PSUM_OFIFO_OVF_FLAG_EN
  ,
  output logic                   o_ovf
`endif
);

  localparam int aw = $clog2(depth);
  localparam logic [aw:0] ptr_one = (aw+1)'(1);

  logic [col-1:0] empty;
  logic [col-1:0] full;
  logic           pop;
`ifdef PSUM_OFIFO_OVF_FLAG_EN
  logic [col-1:0] drop;
`endif

  assign o_valid = ~|empty;
  assign o_empty = &empty;
  assign o_full  = |full;
  assign pop     = rd & o_valid;

  for (genvar c = 0; c < col; c++) begin : g_col
    logic [aw:0]        wr_ptr;
    logic [aw:0]        rd_ptr;
    logic [psum_bw-1:0] mem [depth];
    logic               accept;

    assign empty[c] = (wr_ptr == rd_ptr);
    assign full[c]  = (wr_ptr[aw] != rd_ptr[aw]) && (wr_ptr[aw-1:0] == rd_ptr[aw-1:0]);
    // A full column still accepts a write when the same edge frees its head slot.
    assign accept   = wr[c] && (!full[c] || pop);
`ifdef PSUM_OFIFO_OVF_FLAG_EN
    assign drop[c]  = wr[c] && full[c] && !pop;
`endif

    always_ff @(posedge clk) begin
      if (reset) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (accept) wr_ptr <= wr_ptr + ptr_one;
        if (pop)    rd_ptr <= rd_ptr + ptr_one;
      end
    end

    always_ff @(posedge clk) begin
      if (!reset && accept) mem[wr_ptr[aw-1:0]] <= in[psum_bw*c +: psum_bw];
    end

    assign out[psum_bw*c +: psum_bw] = mem[rd_ptr[aw-1:0]];
  end

`ifdef PSUM_OFIFO_OVF_FLAG_EN
  always_ff @(posedge clk) begin
    if (reset)      o_ovf <= 1'b0;
    else if (|drop) o_ovf <= 1'b1;
  end
`endif

endmodule
